// File: rtl/fpalu_mac_seq.sv
// rtl/fpalu_mac_seq.sv - FP16 dot-product sequencer time-sharing one FPALU for MUL16i/ADD29i
module fpalu_mac_seq #(
  parameter int ALU_LAT  = 1,
  parameter int MAX_TAPS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  taps,
  input  logic [8:0]  dbase,
  output logic        busy,
  output logic        done,
  output logic        res_sgn,
  output logic [5:0]  res_exp,
  output logic [21:0] res_man,
  output logic [5:0]  caddr,
  input  logic [15:0] cin,
  output logic [8:0]  daddr,
  input  logic [15:0] din,
  output logic [1:0]  alu_opcode,
  output logic        alu_a_sgn,
  output logic [5:0]  alu_a_exp,
  output logic [21:0] alu_a_man,
  output logic        alu_b_sgn,
  output logic [5:0]  alu_b_exp,
  output logic [21:0] alu_b_man,
  input  logic        alu_y_sgn,
  input  logic [5:0]  alu_y_exp,
  input  logic [21:0] alu_y_man
);

  localparam int WW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [WW-1:0] LAT_W = WW'(ALU_LAT);
  localparam logic [6:0]    MAX_N = 7'(MAX_TAPS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [5:0]    k_q, k_d;
  logic [6:0]    n_q, n_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [28:0]   prod_q, prod_d;
  logic [28:0]   acc_q, acc_d;
  logic [28:0]   res_q, res_d;
  logic [5:0]    caddr_q, caddr_d;
  logic [8:0]    daddr_q, daddr_d;

  logic [28:0] y;
  logic [28:0] op_a;
  logic [28:0] op_b;

  assign y = {alu_y_sgn, alu_y_exp, alu_y_man};

  // Unified operand: no hidden bit, the ALU owns number semantics.
  function automatic logic [28:0] expand(input logic [15:0] w);
    return {w[15], 1'b0, w[14:10], 12'b0, w[9:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    res_d   = res_q;
    caddr_d = caddr_q;
    daddr_d = daddr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = (taps > MAX_N) ? MAX_N : taps;
          caddr_d = 6'd0;
          daddr_d = dbase;
          k_d     = 6'd0;
          acc_d   = 29'd0;
          wcnt_d  = '0;
          state_d = (taps == 7'd0) ? S_DONE : S_MUL;
        end
      end
      S_MUL: begin
        if (wcnt_q == LAT_W) begin
          prod_d  = y;
          wcnt_d  = '0;
          state_d = S_ADD;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      S_ADD: begin
        if (wcnt_q == LAT_W) begin
          acc_d  = y;
          wcnt_d = '0;
          if ({1'b0, k_q} == n_q - 7'd1) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 6'd1;
            caddr_d = caddr_q + 6'd1;
            daddr_d = daddr_q + 9'd1;
            state_d = S_MUL;
          end
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: begin
        res_d   = acc_q;
        state_d = S_IDLE;
      end
    endcase
  end

  // MUL operands pass straight through from the asynchronous memory reads.
  always_comb begin
    alu_opcode = OP_IDLE;
    op_a       = 29'd0;
    op_b       = 29'd0;
    case (state_q)
      S_MUL: begin
        alu_opcode = OP_MUL;
        op_a       = expand(din);
        op_b       = expand(cin);
      end
      S_ADD: begin
        alu_opcode = OP_ADD;
        op_a       = acc_q;
        op_b       = prod_q;
      end
      default: begin
        alu_opcode = OP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 6'd0;
      n_q     <= 7'd0;
      wcnt_q  <= '0;
      prod_q  <= 29'd0;
      acc_q   <= 29'd0;
      res_q   <= 29'd0;
      caddr_q <= 6'd0;
      daddr_q <= 9'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      caddr_q <= caddr_d;
      daddr_q <= daddr_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign caddr     = caddr_q;
  assign daddr     = daddr_q;
  assign res_sgn   = res_q[28];
  assign res_exp   = res_q[27:22];
  assign res_man   = res_q[21:0];
  assign alu_a_sgn = op_a[28];
  assign alu_a_exp = op_a[27:22];
  assign alu_a_man = op_a[21:0];
  assign alu_b_sgn = op_b[28];
  assign alu_b_exp = op_b[27:22];
  assign alu_b_man = op_b[21:0];

endmodule

// File: tb/tb_fpalu_mac_seq.sv
// tb/tb_fpalu_mac_seq.sv - randomized self-checking bench for fpalu_mac_seq against a dot-product model
module tb_fpalu_mac_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  taps = 7'd0;
  logic [8:0]  dbase = 9'd0;
  logic        busy, done;
  logic        res_sgn;
  logic [5:0]  res_exp;
  logic [21:0] res_man;
  logic [5:0]  caddr;
  logic [8:0]  daddr;
  logic [15:0] cin, din;
  logic [1:0]  alu_opcode;
  logic        alu_a_sgn, alu_b_sgn, alu_y_sgn;
  logic [5:0]  alu_a_exp, alu_b_exp, alu_y_exp;
  logic [21:0] alu_a_man, alu_b_man, alu_y_man;

  logic [15:0] dmem [512];
  logic [15:0] cmem [64];
  logic [28:0] y_q;

  int errors = 0;
  int checks = 0;

  int          done_cyc, done_cnt, mul_cnt, caddr_max, nz_ops, busy_c1, busy_after, busy_post_rst;
  logic [1:0]  ops [$];
  int          ent_d [$];
  int          ent_c [$];
  logic [28:0] res_after, mul_a0, mul_b0;

  fpalu_mac_seq dut (
    .clk(clk), .rst(rst), .start(start), .taps(taps), .dbase(dbase),
    .busy(busy), .done(done),
    .res_sgn(res_sgn), .res_exp(res_exp), .res_man(res_man),
    .caddr(caddr), .cin(cin), .daddr(daddr), .din(din),
    .alu_opcode(alu_opcode),
    .alu_a_sgn(alu_a_sgn), .alu_a_exp(alu_a_exp), .alu_a_man(alu_a_man),
    .alu_b_sgn(alu_b_sgn), .alu_b_exp(alu_b_exp), .alu_b_man(alu_b_man),
    .alu_y_sgn(alu_y_sgn), .alu_y_exp(alu_y_exp), .alu_y_man(alu_y_man)
  );

  always #5 clk = ~clk;

  assign din = dmem[daddr];
  assign cin = cmem[caddr];

  // Stand-in ALU; ADD is deliberately non-commutative so operand order matters.
  function automatic logic [28:0] f_mul(input logic [28:0] a, input logic [28:0] b);
    logic [5:0]  e;
    logic [43:0] m;
    e = a[27:22] + b[27:22];
    m = a[21:0] * b[21:0];
    return {a[28] ^ b[28], e, m[21:0]};
  endfunction

  function automatic logic [28:0] f_add(input logic [28:0] a, input logic [28:0] b);
    return a + a + a + b;
  endfunction

  function automatic logic [28:0] expand(input logic [15:0] w);
    return {w[15], 1'b0, w[14:10], 12'b0, w[9:0]};
  endfunction

  // One-cycle ALU: result registered on the edge after operands are presented.
  always @(posedge clk) begin
    if (alu_opcode == 2'b10)
      y_q <= f_mul({alu_a_sgn, alu_a_exp, alu_a_man}, {alu_b_sgn, alu_b_exp, alu_b_man});
    else if (alu_opcode == 2'b11)
      y_q <= f_add({alu_a_sgn, alu_a_exp, alu_a_man}, {alu_b_sgn, alu_b_exp, alu_b_man});
    else
      y_q <= 29'd0;
  end
  assign alu_y_sgn = y_q[28];
  assign alu_y_exp = y_q[27:22];
  assign alu_y_man = y_q[21:0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 512; i++) dmem[i] = 16'($urandom);
    for (int i = 0; i < 64; i++) cmem[i] = 16'($urandom);
  endtask

  task automatic run(input logic [6:0] t, input logic [8:0] db, input int budget,
                     input int pulse_cyc, input int rst_cyc, output logic [28:0] expv);
    int         n;
    logic [1:0] prev_op;
    n = (t > 7'd64) ? 64 : int'(t);
    expv = 29'd0;
    for (int k = 0; k < n; k++)
      expv = f_add(expv, f_mul(expand(dmem[(int'(db) + k) % 512]), expand(cmem[k])));
    done_cyc = -1; done_cnt = 0; mul_cnt = 0; caddr_max = 0; nz_ops = 0;
    busy_c1 = -1; busy_after = -1; busy_post_rst = -1;
    ops.delete(); ent_d.delete(); ent_c.delete();
    res_after = 'x; mul_a0 = 'x; mul_b0 = 'x;
    prev_op = 2'b00;
    @(negedge clk);
    start = 1'b1; taps = t; dbase = db;
    @(posedge clk);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) busy_c1 = int'(busy);
      ops.push_back(alu_opcode);
      if (alu_opcode != 2'b00) nz_ops++;
      if (alu_opcode == 2'b10 && prev_op != 2'b10) begin
        mul_cnt++;
        ent_d.push_back(int'(daddr));
        ent_c.push_back(int'(caddr));
        if (mul_cnt == 1) begin
          mul_a0 = {alu_a_sgn, alu_a_exp, alu_a_man};
          mul_b0 = {alu_b_sgn, alu_b_exp, alu_b_man};
        end
      end
      prev_op = alu_opcode;
      if (int'(caddr) > caddr_max) caddr_max = int'(caddr);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc > 0 && c == done_cyc + 1) begin
        res_after  = {res_sgn, res_exp, res_man};
        busy_after = int'(busy);
      end
      if (rst_cyc > 0 && c == rst_cyc + 1) begin
        busy_post_rst = int'(busy);
        rst = 1'b0;
      end
      start = (c == pulse_cyc);
      if (start) taps = 7'd5;
      if (c == rst_cyc) rst = 1'b1;
      if (done_cyc > 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [28:0] e;
    fill_mem();

    // Reset with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'($urandom); taps = 7'($urandom); dbase = 9'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("rst_ctl", {busy, done, caddr, daddr, alu_opcode}, 64'd0);
      check("rst_ops", {alu_a_sgn, alu_a_exp, alu_a_man, alu_b_sgn, alu_b_exp, alu_b_man}, 64'd0);
      check("rst_res", {res_sgn, res_exp, res_man}, 64'd0);
    end
    rst = 1'b0; start = 1'b0;

    // Single tap.
    dmem[0] = 16'h3C00; cmem[0] = 16'h4000;
    run(7'd1, 9'd0, 20, 0, 0, e);
    check("busy_rise", 64'(busy_c1), 64'd1);
    check("op_trace", {ops[0], ops[1], ops[2], ops[3]}, 64'b10101111);
    check("mul_a", 64'(mul_a0), {35'd0, 1'b0, 6'h0F, 22'h0});
    check("mul_b", 64'(mul_b0), {35'd0, 1'b0, 6'h10, 22'h0});
    check("t1_done", 64'(done_cyc), 64'd5);
    check("t1_res", 64'(res_after), 64'(e));
    check("t1_busy_fall", 64'(busy_after), 64'd0);

    // Address wrap.
    fill_mem();
    run(7'd3, 9'd510, 30, 0, 0, e);
    check("wrap_mul_cnt", 64'(mul_cnt), 64'd3);
    check("wrap_daddr", {27'd0, 9'(ent_d[0]), 9'(ent_d[1]), 9'(ent_d[2])}, {37'd0, 9'd510, 9'd511, 9'd0});
    check("wrap_caddr", {46'd0, 6'(ent_c[0]), 6'(ent_c[1]), 6'(ent_c[2])}, {46'd0, 6'd0, 6'd1, 6'd2});
    check("wrap_done", 64'(done_cyc), 64'd13);
    check("wrap_res", 64'(res_after), 64'(e));

    // Zero taps.
    run(7'd0, 9'($urandom), 10, 0, 0, e);
    check("z_done", 64'(done_cyc), 64'd1);
    check("z_res", 64'(res_after), 64'd0);
    check("z_ops", 64'(nz_ops), 64'd0);

    // Start while busy, and start coinciding with DONE.
    fill_mem();
    run(7'd2, 9'($urandom), 30, 3, 0, e);
    check("pb_done", 64'(done_cyc), 64'd9);
    check("pb_done_cnt", 64'(done_cnt), 64'd1);
    check("pb_mul_cnt", 64'(mul_cnt), 64'd2);
    check("pb_res", 64'(res_after), 64'(e));
    run(7'd2, 9'($urandom), 30, 9, 0, e);
    check("pd_done", 64'(done_cyc), 64'd9);
    check("pd_idle", 64'(busy_after), 64'd0);

    // Reset mid-run, then a fresh run.
    run(7'd4, 9'($urandom), 40, 0, 6, e);
    check("mr_idle", 64'(busy_post_rst), 64'd0);
    check("mr_no_done", 64'(done_cnt), 64'd0);
    fill_mem();
    run(7'd2, 9'($urandom), 30, 0, 0, e);
    check("fr_done", 64'(done_cyc), 64'd9);
    check("fr_res", 64'(res_after), 64'(e));

    // Clamp.
    fill_mem();
    run(7'd100, 9'($urandom), 300, 0, 0, e);
    check("cl_caddr_max", 64'(caddr_max), 64'd63);
    check("cl_done", 64'(done_cyc), 64'd257);
    check("cl_mul_cnt", 64'(mul_cnt), 64'd64);
    check("cl_res", 64'(res_after), 64'(e));

    // Random runs.
    for (int i = 0; i < 6; i++) begin
      int t;
      fill_mem();
      t = $urandom_range(1, 10);
      run(7'(t), 9'($urandom), 60, 0, 0, e);
      check("rnd_done", 64'(done_cyc), 64'(1 + 4 * t));
      check("rnd_res", 64'(res_after), 64'(e));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
